// File: rtl/usb_protocol_fsm_if.sv
// Encoder/decoder side of the host USB transaction engine.
// master: transaction engine (drives encoder request, consumes decoder result).
// slave : packet encoder/decoder (or a model of it).
//   enc_start/enc_pid/enc_token/enc_data : transmit request, fields stable until enc_done
//   enc_done                             : encoder finished transmitting
//   dec_valid/dec_pid/dec_data/dec_err   : received packet and its CRC/bit-stuff status
interface usb_protocol_fsm_if;
  logic        enc_start;
  logic [3:0]  enc_pid;
  logic [10:0] enc_token;
  logic [63:0] enc_data;
  logic        enc_done;
  logic        dec_valid;
  logic [3:0]  dec_pid;
  logic [63:0] dec_data;
  logic        dec_err;

  modport master (
    output enc_start, enc_pid, enc_token, enc_data,
    input  enc_done, dec_valid, dec_pid, dec_data, dec_err
  );

  modport slave (
    input  enc_start, enc_pid, enc_token, enc_data,
    output enc_done, dec_valid, dec_pid, dec_data, dec_err
  );
endinterface

// File: rtl/usb_protocol_fsm.sv
// Host-side USB transaction engine: takes one request at a time from rwFSM,
// drives the packet encoder, waits for device responses and retries data
// phases on NAK, CRC error or response timeout.
// Optional feature macro: DATA_TOGGLE_EN (DATA0/DATA1 toggle tracking).
// Ports:
//   clk, rst_L     : clock, synchronous active-low reset
//   packet_type    : 0 NONE, 1 IN_TOK, 2 OUT_TOK, 3 OUT_DATA, 4 IN_DATA
//   rw_dout        : OUT_DATA payload, sampled at accept
//   protocol_free  : engine idle (combinational from state)
//   timeout        : one-cycle pulse, data phase failed after MAX_RETRY attempts
//   rw_din         : last successfully received IN data
//   phy            : encoder/decoder interface (master side)
module usb_protocol_fsm #(
  parameter int unsigned RESP_TIMEOUT = 255,
  parameter int unsigned MAX_RETRY    = 8,
  parameter logic [6:0]  DEV_ADDR     = 7'd5,
  parameter logic [3:0]  ENDP         = 4'd4
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic [2:0]          packet_type,
  input  logic [63:0]         rw_dout,
  output logic                protocol_free,
  output logic                timeout,
  output logic [63:0]         rw_din,
  usb_protocol_fsm_if.master  phy
);

  localparam int unsigned RESP_W  = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [2:0] PT_IN_TOK   = 3'd1;
  localparam logic [2:0] PT_OUT_TOK  = 3'd2;
  localparam logic [2:0] PT_OUT_DATA = 3'd3;
  localparam logic [2:0] PT_IN_DATA  = 3'd4;

  typedef enum logic [2:0] {
    IDLE, TOK_TX, DOUT_TX, HS_WAIT, DIN_WAIT, ACK_TX, NAK_TX
  } state_t;

  state_t               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [RESP_W-1:0]    resp_q, resp_d;
  logic                 timeout_q, timeout_d;
  logic                 enc_start_q, enc_start_d;
  logic [3:0]           enc_pid_q, enc_pid_d;
  logic [63:0]          enc_data_q, enc_data_d;
  logic [63:0]          rw_din_q, rw_din_d;
  logic                 fail;
  logic [3:0]           tx_pid;
  logic [3:0]           rx_pid;

`ifdef DATA_TOGGLE_EN
  logic tx_tog_q, tx_tog_d;
  logic rx_tog_q, rx_tog_d;

  assign tx_pid = tx_tog_q ? PID_DATA1 : PID_DATA0;
  assign rx_pid = rx_tog_q ? PID_DATA1 : PID_DATA0;
`else
  assign tx_pid = PID_DATA0;
  assign rx_pid = PID_DATA0;
`endif

  function automatic logic is_tx(input state_t s);
    return (s == TOK_TX) || (s == DOUT_TX) || (s == ACK_TX) || (s == NAK_TX);
  endfunction

  // Held low during reset so upstream never issues a request into a resetting engine.
  assign protocol_free = rst_L && (state_q == IDLE);
  assign timeout       = timeout_q;
  assign rw_din        = rw_din_q;
  assign phy.enc_start = enc_start_q;
  assign phy.enc_pid   = enc_pid_q;
  assign phy.enc_data  = enc_data_q;
  assign phy.enc_token = {ENDP, DEV_ADDR};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      resp_q      <= '0;
      timeout_q   <= 1'b0;
      enc_start_q <= 1'b0;
      enc_pid_q   <= '0;
      enc_data_q  <= '0;
      rw_din_q    <= '0;
`ifdef DATA_TOGGLE_EN
      tx_tog_q    <= 1'b0;
      rx_tog_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      enc_start_q <= enc_start_d;
      enc_pid_q   <= enc_pid_d;
      enc_data_q  <= enc_data_d;
      rw_din_q    <= rw_din_d;
`ifdef DATA_TOGGLE_EN
      tx_tog_q    <= tx_tog_d;
      rx_tog_q    <= rx_tog_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    resp_d     = '0;
    timeout_d  = 1'b0;
    enc_pid_d  = enc_pid_q;
    enc_data_d = enc_data_q;
    rw_din_d   = rw_din_q;
    fail       = 1'b0;
`ifdef DATA_TOGGLE_EN
    tx_tog_d   = tx_tog_q;
    rx_tog_d   = rx_tog_q;
`endif

    case (state_q)
      IDLE: begin
        // enc_data doubles as the latched request payload for all retries.
        if (packet_type inside {PT_IN_TOK, PT_OUT_TOK, PT_OUT_DATA, PT_IN_DATA}) begin
          enc_data_d = rw_dout;
          retry_d    = '0;
        end
        case (packet_type)
          PT_IN_TOK:   begin state_d = TOK_TX;  enc_pid_d = PID_IN;  end
          PT_OUT_TOK:  begin state_d = TOK_TX;  enc_pid_d = PID_OUT; end
          PT_OUT_DATA: begin state_d = DOUT_TX; enc_pid_d = tx_pid;  end
          PT_IN_DATA:  state_d = DIN_WAIT;
          default:     ;
        endcase
      end

      TOK_TX:  if (phy.enc_done) state_d = IDLE;
      DOUT_TX: if (phy.enc_done) state_d = HS_WAIT;
      ACK_TX:  if (phy.enc_done) state_d = IDLE;
      NAK_TX:  if (phy.enc_done) state_d = DIN_WAIT;

      HS_WAIT: begin
        // A response on the terminal-count cycle wins over the timeout.
        if (phy.dec_valid) begin
          if (phy.dec_pid == PID_ACK && !phy.dec_err) begin
            state_d = IDLE;
`ifdef DATA_TOGGLE_EN
            tx_tog_d = ~tx_tog_q;
`endif
          end else begin
            fail = 1'b1;
          end
        end else if (resp_q == RESP_W'(RESP_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          resp_d = resp_q + RESP_W'(1);
        end
      end

      DIN_WAIT: begin
        if (phy.dec_valid) begin
          if (phy.dec_pid == rx_pid && !phy.dec_err) begin
            state_d   = ACK_TX;
            enc_pid_d = PID_ACK;
            rw_din_d  = phy.dec_data;
`ifdef DATA_TOGGLE_EN
            rx_tog_d  = ~rx_tog_q;
`endif
          end else begin
            fail = 1'b1;
          end
        end else if (resp_q == RESP_W'(RESP_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          resp_d = resp_q + RESP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared retry/abort handling for both data-phase wait states.
    if (fail) begin
      if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
      end else begin
        retry_d = retry_q + RETRY_W'(1);
        if (state_q == HS_WAIT) begin
          state_d   = DOUT_TX;
          enc_pid_d = tx_pid;
        end else begin
          state_d   = NAK_TX;
          enc_pid_d = PID_NAK;
        end
      end
    end

    // Every TX state is entered only from a non-TX state, so entry = pulse.
    enc_start_d = is_tx(state_d) && !is_tx(state_q);
  end

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Directed self-checking bench for usb_protocol_fsm.
module tb_usb_protocol_fsm;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_L;
  logic [2:0]  packet_type;
  logic [63:0] rw_dout;
  logic        protocol_free;
  logic        timeout;
  logic [63:0] rw_din;

  usb_protocol_fsm_if phy_if ();

  usb_protocol_fsm dut (
    .clk           (clk),
    .rst_L         (rst_L),
    .packet_type   (packet_type),
    .rw_dout       (rw_dout),
    .protocol_free (protocol_free),
    .timeout       (timeout),
    .rw_din        (rw_din),
    .phy           (phy_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int to_cnt = 0;

  // Mid-cycle monitor of encoder requests and timeout pulses.
  always @(negedge clk) begin
    if (rst_L && phy_if.enc_start) start_cnt++;
    if (rst_L && timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] pt, input logic [63:0] d);
    packet_type = pt;
    rw_dout     = d;
    tick();
    packet_type = 3'd0;
    rw_dout     = '0;
  endtask

  task automatic enc_finish();
    phy_if.enc_done = 1'b1;
    tick();
    phy_if.enc_done = 1'b0;
  endtask

  task automatic respond(input logic [3:0] pid, input logic [63:0] d, input logic err);
    phy_if.dec_valid = 1'b1;
    phy_if.dec_pid   = pid;
    phy_if.dec_data  = d;
    phy_if.dec_err   = err;
    tick();
    phy_if.dec_valid = 1'b0;
    phy_if.dec_err   = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t0;
    int cycles;
    logic seen;
    logic start_prev;

    rst_L            = 1'b0;
    packet_type      = 3'd0;
    rw_dout          = '0;
    phy_if.enc_done  = 1'b0;
    phy_if.dec_valid = 1'b0;
    phy_if.dec_pid   = '0;
    phy_if.dec_data  = '0;
    phy_if.dec_err   = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_free",      protocol_free,   0);
    check("rst_timeout",   timeout,         0);
    check("rst_enc_start", phy_if.enc_start, 0);
    check("rst_enc_pid",   phy_if.enc_pid,  0);
    check("rst_enc_data",  phy_if.enc_data, 0);
    check("rst_rw_din",    rw_din,          0);
    rst_L = 1'b1;
    #1;
    check("rel_free", protocol_free, 1);
    tick();

    // OUT token
    send_req(3'd2, 64'h0);
    check("tok_start", phy_if.enc_start, 1);
    check("tok_pid",   phy_if.enc_pid,   PID_OUT);
    check("tok_token", phy_if.enc_token, 11'h205);
    check("tok_busy",  protocol_free,    0);
    tick();
    check("tok_pulse", phy_if.enc_start, 0);
    tick();
    tick();
    check("tok_wait_busy", protocol_free, 0);
    enc_finish();
    check("tok_free", protocol_free, 1);

    // OUT_DATA: NAK, NAK, ACK
    s0 = start_cnt;
    t0 = to_cnt;
    send_req(3'd3, 64'hDEADBEEF_00000001);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("od_start%0d", i), phy_if.enc_start, 1);
      check($sformatf("od_pid%0d", i),   phy_if.enc_pid,   PID_DATA0);
      check($sformatf("od_data%0d", i),  phy_if.enc_data,  64'hDEADBEEF_00000001);
      tick();
      enc_finish();
      tick();
      respond((i < 2) ? PID_NAK : PID_ACK, 64'h0, 1'b0);
    end
    check("od_free",   protocol_free,  1);
    check("od_starts", start_cnt - s0, 3);
    check("od_no_to",  to_cnt - t0,    0);

    // IN_DATA: CRC error first (NAK), then good DATA0
    send_req(3'd4, 64'h0);
    check("in_busy",     protocol_free,    0);
    check("in_no_start", phy_if.enc_start, 0);
    tick();
    tick();
    respond(PID_DATA0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("in_err_nak_start", phy_if.enc_start, 1);
    check("in_err_nak_pid",   phy_if.enc_pid,   PID_NAK);
    check("in_err_rw_din",    rw_din,           0);
    tick();
    enc_finish();
    tick();
    respond(PID_DATA0, 64'h0123456789ABCDEF, 1'b0);
    check("in_ack_start", phy_if.enc_start, 1);
    check("in_ack_pid",   phy_if.enc_pid,   PID_ACK);
    check("in_rw_din",    rw_din,           64'h0123456789ABCDEF);
    tick();
    enc_finish();
    check("in_free", protocol_free, 1);

    // IN_DATA with no response: 8 windows, 7 NAKs, then timeout
    s0 = start_cnt;
    t0 = to_cnt;
    seen = 1'b0;
    cycles = 0;
    start_prev = 1'b0;
    send_req(3'd4, 64'h0);
    for (int c = 0; c < 3000 && !seen; c++) begin
      phy_if.enc_done = start_prev;
      start_prev = phy_if.enc_start;
      tick();
      cycles++;
      if (timeout) seen = 1'b1;
    end
    phy_if.enc_done = 1'b0;
    check("to_seen",   seen,           1);
    check("to_cycles", cycles,         2054);
    check("to_free",   protocol_free,  1);
    check("to_naks",   start_cnt - s0, 7);
    check("to_pid",    phy_if.enc_pid, PID_NAK);
    check("to_rw_din", rw_din,         64'h0123456789ABCDEF);
    tick();
    check("to_pulse", timeout,     0);
    check("to_count", to_cnt - t0, 1);

    // ACK exactly on the terminal response-count cycle is a response
    s0 = start_cnt;
    t0 = to_cnt;
    send_req(3'd3, 64'h55);
    tick();
    enc_finish();
    repeat (254) tick();
    respond(PID_ACK, 64'h0, 1'b0);
    check("edge_free",   protocol_free,  1);
    check("edge_no_to",  to_cnt - t0,    0);
    check("edge_starts", start_cnt - s0, 1);

    // Reserved packet type is ignored
    packet_type = 3'd5;
    tick();
    packet_type = 3'd0;
    check("rsv_free",  protocol_free,    1);
    check("rsv_start", phy_if.enc_start, 0);

    // Reset during HS_WAIT after one retry
    t0 = to_cnt;
    send_req(3'd3, 64'hA5A5);
    tick();
    enc_finish();
    tick();
    respond(PID_NAK, 64'h0, 1'b0);
    tick();
    enc_finish();
    tick();
    rst_L = 1'b0;
    tick();
    check("mrst_free_low", protocol_free, 0);
    check("mrst_rw_din",   rw_din,        0);
    check("mrst_timeout",  timeout,       0);
    rst_L = 1'b1;
    tick();
    check("mrst_free", protocol_free, 1);
    check("mrst_no_to", to_cnt - t0,  0);

    // Fresh OUT_DATA gets all eight attempts after the reset
    send_req(3'd3, 64'h1234);
    for (int i = 0; i < 8; i++) begin
      tick();
      enc_finish();
      tick();
      respond(PID_NAK, 64'h0, 1'b0);
      if (i < 7) begin
        check($sformatf("rt_retry%0d", i), phy_if.enc_start, 1);
        check($sformatf("rt_no_to%0d", i), timeout, 0);
      end else begin
        check("rt_timeout", timeout,       1);
        check("rt_free",    protocol_free, 1);
      end
    end
    tick();

`ifdef DATA_TOGGLE_EN
    // Toggle sequence after reset: DATA0, DATA1 out; DATA1 in when DATA0 expected
    send_req(3'd3, 64'h1);
    check("tg_pid0", phy_if.enc_pid, PID_DATA0);
    tick();
    enc_finish();
    tick();
    respond(PID_ACK, 64'h0, 1'b0);
    send_req(3'd3, 64'h2);
    check("tg_pid1", phy_if.enc_pid, PID_DATA1);
    tick();
    enc_finish();
    tick();
    respond(PID_ACK, 64'h0, 1'b0);
    send_req(3'd4, 64'h0);
    tick();
    respond(PID_DATA1, 64'hBAD, 1'b0);
    check("tg_rx_nak", phy_if.enc_pid, PID_NAK);
    check("tg_rx_din", rw_din,         0);
    tick();
    enc_finish();
    tick();
    respond(PID_DATA0, 64'hC0DE, 1'b0);
    check("tg_rx_ack", phy_if.enc_pid, PID_ACK);
    check("tg_rx_data", rw_din,        64'hC0DE);
    tick();
    enc_finish();
    check("tg_free", protocol_free, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
